// File: rtl/cp_filter_pkg.sv
// Shared types and arithmetic helpers for the digital charge pump / PI loop filter.
// The error code is a 2-bit signed value so it can feed the arithmetic paths directly.
package cp_filter_pkg;

    typedef logic signed [1:0] err_t;

    localparam err_t ERR_ZERO = 2'sb00;
    localparam err_t ERR_POS  = 2'sb01;
    localparam err_t ERR_NEG  = 2'sb11;

    // Wide enough for any accumulator or control-word sum this block will ever form.
    localparam int SAT_W = 48;
    typedef logic signed [SAT_W-1:0] sat_t;

    function automatic err_t err_decode(input logic up_v, input logic dn_v);
        err_t e;
        e = ERR_ZERO;
        if (up_v && !dn_v) begin
            e = ERR_POS;
        end else if (dn_v && !up_v) begin
            e = ERR_NEG;
        end
        return e;
    endfunction

    function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t lo, input sat_t hi);
        sat_t s;
        s = a + b;
        if (s < lo) begin
            s = lo;
        end else if (s > hi) begin
            s = hi;
        end
        return s;
    endfunction

endpackage

// File: rtl/cp_lock_detect.sv
// Lock detector: consecutive zero-error / nonzero-error run counters driving a sticky lock flag.
// Isolated PFD pulses clear the zero run but never reach the unlock threshold on their own.
module cp_lock_detect
    import cp_filter_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  err_t err,
    output logic locked
);

    localparam int ZW = $clog2(LOCK_CNT + 1);
    localparam int NW = $clog2(UNLOCK_CNT + 1);
    localparam logic [ZW-1:0] Z_TOP = ZW'(LOCK_CNT - 1);
    localparam logic [NW-1:0] N_TOP = NW'(UNLOCK_CNT - 1);

    logic [ZW-1:0] zrun;
    logic [NW-1:0] nzrun;
    logic [ZW-1:0] zrun_next;
    logic [NW-1:0] nzrun_next;
    logic          locked_next;
    logic          err_zero;

    always_comb begin
        err_zero    = (err == ERR_ZERO);
        zrun_next   = zrun;
        nzrun_next  = nzrun;
        locked_next = locked;
        if (err_zero) begin
            nzrun_next = '0;
            if (zrun != Z_TOP) begin
                zrun_next = zrun + 1'b1;
            end
            if (zrun == Z_TOP) begin
                locked_next = 1'b1;
            end
        end else begin
            zrun_next = '0;
            if (nzrun != N_TOP) begin
                nzrun_next = nzrun + 1'b1;
            end
            if (nzrun == N_TOP) begin
                locked_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zrun   <= '0;
            nzrun  <= '0;
            locked <= 1'b0;
        end else begin
            zrun   <= zrun_next;
            nzrun  <= nzrun_next;
            locked <= locked_next;
        end
    end

endmodule

// File: rtl/dig_charge_pump_filter.sv
// Digital charge pump and PI loop filter between the PFD and the DCO/NCO.
// Two register stages: up/dn capture, then integrator plus saturating control word.
module dig_charge_pump_filter
    import cp_filter_pkg::*;
#(
    parameter int CTRL_W     = 16,
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 6,
    parameter int CTRL_INIT  = 32768,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              dn,
    input  logic              freeze,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ctrl_upd,
    output logic              locked
);

    localparam int ACC_W = CTRL_W + KI_SHIFT;
    localparam int MID_W = CTRL_W + 2;

    localparam logic [ACC_W-1:0]  ACC_INIT  = ACC_W'(CTRL_INIT) << KI_SHIFT;
    localparam logic [CTRL_W-1:0] CTRL_RST  = CTRL_W'(CTRL_INIT);
    localparam sat_t              ACC_MAX   = sat_t'({ACC_W{1'b1}});
    localparam sat_t              CTRL_MAX  = sat_t'({CTRL_W{1'b1}});
    localparam sat_t              SAT_ZERO  = '0;

    logic                    up_q;
    logic                    dn_q;
    logic [ACC_W-1:0]        acc;
    err_t                    err;
    logic [ACC_W-1:0]        acc_next;
    logic signed [MID_W-1:0] ctrl_mid;
    logic [CTRL_W-1:0]       ctrl_next;

    always_comb begin
        err = err_decode(up_q, dn_q);

        acc_next = acc;
        if (!freeze) begin
            acc_next = ACC_W'(sat_add(sat_t'(acc), sat_t'(err), SAT_ZERO, ACC_MAX));
        end

        // Proportional kick rides on the integrator value being written this cycle.
        ctrl_mid  = $signed({2'b00, acc_next[ACC_W-1:KI_SHIFT]}) + (MID_W'(err) <<< KP_SHIFT);
        ctrl_next = CTRL_W'(sat_add(sat_t'(ctrl_mid), SAT_ZERO, SAT_ZERO, CTRL_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            acc      <= ACC_INIT;
            ctrl     <= CTRL_RST;
            ctrl_upd <= 1'b0;
        end else begin
            up_q     <= up;
            dn_q     <= dn;
            acc      <= acc_next;
            ctrl     <= ctrl_next;
            ctrl_upd <= (ctrl_next != ctrl);
        end
    end

    cp_lock_detect #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock (
        .clk    (clk),
        .rst    (rst),
        .err    (err),
        .locked (locked)
    );

endmodule

// File: tb/tb_dig_charge_pump_filter.sv
// Self-checking bench: default-parameter filter plus a narrow instance so saturation is reachable quickly.
module tb_dig_charge_pump_filter;

    localparam int CW  = 16, KP  = 2, KI  = 6, INIT  = 32768;
    localparam int SCW = 8,  SKP = 2, SKI = 2, SINIT = 128;

    logic clk;
    logic rst, up, dn, freeze;
    logic [CW-1:0] ctrl;
    logic ctrl_upd, locked;
    logic s_rst, s_up, s_dn, s_freeze;
    logic [SCW-1:0] s_ctrl;
    logic s_ctrl_upd, s_locked;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint acc;
        longint ctrl;
        bit     upd;
        bit     locked;
        bit     upq;
        bit     dnq;
        int     zl;
        int     nzl;
    } mdl_t;

    mdl_t m, sm;

    dig_charge_pump_filter u_dut (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .freeze(freeze),
        .ctrl(ctrl), .ctrl_upd(ctrl_upd), .locked(locked)
    );

    dig_charge_pump_filter #(
        .CTRL_W(SCW), .KP_SHIFT(SKP), .KI_SHIFT(SKI), .CTRL_INIT(SINIT),
        .LOCK_CNT(16), .UNLOCK_CNT(4)
    ) u_small (
        .clk(clk), .rst(s_rst), .up(s_up), .dn(s_dn), .freeze(s_freeze),
        .ctrl(s_ctrl), .ctrl_upd(s_ctrl_upd), .locked(s_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint clamp(longint v, longint hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic mdl_t mdl_init(int cw, int ki, longint init);
        mdl_t r;
        r.acc = init * (longint'(1) << ki);
        r.ctrl = init;
        r.upd = 0; r.locked = 0; r.upq = 0; r.dnq = 0; r.zl = 0; r.nzl = 0;
        if (cw < 1) r.ctrl = 0;
        return r;
    endfunction

    // Behavioural reference: integer PI law with clamps, plus unbounded run lengths.
    function automatic mdl_t mdl_step(mdl_t mi, bit u, bit d, bit f, int cw, int kp, int ki);
        mdl_t r;
        int e;
        longint nc;
        r = mi;
        e = (r.upq && !r.dnq) ? 1 : ((r.dnq && !r.upq) ? -1 : 0);
        if (!f) r.acc = clamp(r.acc + e, (longint'(1) << (cw + ki)) - 1);
        nc = clamp(r.acc / (longint'(1) << ki) + e * (1 << kp), (longint'(1) << cw) - 1);
        r.upd = (nc != r.ctrl);
        r.ctrl = nc;
        if (e == 0) begin r.zl++; r.nzl = 0; end
        else begin r.nzl++; r.zl = 0; end
        if (e == 0 && r.zl >= 16) r.locked = 1;
        if (e != 0 && r.nzl >= 4) r.locked = 0;
        r.upq = u;
        r.dnq = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) m = mdl_init(CW, KI, INIT);
        else     m = mdl_step(m, up, dn, freeze, CW, KP, KI);
        if (s_rst) sm = mdl_init(SCW, SKI, SINIT);
        else       sm = mdl_step(sm, s_up, s_dn, s_freeze, SCW, SKP, SKI);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; up = 0; dn = 0; freeze = 0;
        s_rst = 1; s_up = 0; s_dn = 0; s_freeze = 0;
        m = mdl_init(CW, KI, INIT);
        sm = mdl_init(SCW, SKI, SINIT);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (ctrl !== 16'd32768 || locked !== 1'b0 || ctrl_upd !== 1'b0) begin
                bad++;
                $display("FAIL reset_during cyc=%0d ctrl=%0d locked=%b upd=%b exp ctrl=32768 locked=0 upd=0", i, ctrl, locked, ctrl_upd);
            end
        end
        rst = 0;
        #1;
        total++;
        if (ctrl !== 16'd32768 || locked !== 1'b0 || ctrl_upd !== 1'b0) begin
            bad++;
            $display("FAIL reset_after ctrl=%0d locked=%b upd=%b exp ctrl=32768 locked=0 upd=0", ctrl, locked, ctrl_upd);
        end
    endtask

    task automatic test_pump_up();
        up = 1;
        for (int i = 0; i < 64; i++) begin
            tick();
            total++;
            if (ctrl !== 16'(m.ctrl) || ctrl_upd !== m.upd) begin
                bad++;
                $display("FAIL pump_hold i=%0d ctrl=%0d upd=%b exp ctrl=%0d upd=%b", i, ctrl, ctrl_upd, m.ctrl, m.upd);
            end
        end
        up = 0;
        tick();
        total++;
        if (ctrl !== 16'd32773 || ctrl_upd !== 1'b1) begin
            bad++;
            $display("FAIL pump_peak ctrl=%0d upd=%b exp ctrl=32773 upd=1", ctrl, ctrl_upd);
        end
        tick();
        total++;
        if (ctrl !== 16'd32769 || ctrl_upd !== 1'b1) begin
            bad++;
            $display("FAIL pump_release ctrl=%0d upd=%b exp ctrl=32769 upd=1", ctrl, ctrl_upd);
        end
        tick();
        total++;
        if (ctrl !== 16'd32769 || ctrl_upd !== 1'b0) begin
            bad++;
            $display("FAIL pump_settle ctrl=%0d upd=%b exp ctrl=32769 upd=0", ctrl, ctrl_upd);
        end
    endtask

    task automatic test_overlap();
        longint c0;
        c0 = m.ctrl;
        up = 1; dn = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (ctrl !== 16'(c0) || ctrl_upd !== 1'b0 || ctrl !== 16'(m.ctrl)) begin
                bad++;
                $display("FAIL overlap i=%0d ctrl=%0d upd=%b exp ctrl=%0d upd=0", i, ctrl, ctrl_upd, c0);
            end
        end
        up = 0; dn = 0;
        tick(); tick();
        total++;
        if (ctrl !== 16'(c0)) begin
            bad++;
            $display("FAIL overlap_exit ctrl=%0d exp=%0d", ctrl, c0);
        end
    endtask

    task automatic test_lock();
        up = 1;
        for (int i = 0; i < 6; i++) tick();
        up = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (locked !== m.locked) begin
                bad++;
                $display("FAIL lock_acquire i=%0d locked=%b exp=%b", i, locked, m.locked);
            end
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL lock_final locked=%b exp=1", locked);
        end
        for (int i = 0; i < 20; i++) begin
            up = (i % 2 == 0);
            tick();
            total++;
            if (locked !== 1'b1) begin
                bad++;
                $display("FAIL lock_isolated i=%0d locked=%b exp=1", i, locked);
            end
        end
        up = 1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL lock_three_nz locked=%b exp=1", locked);
        end
        up = 0;
        tick();
        total++;
        if (locked !== 1'b0 || m.locked != 1'b0) begin
            bad++;
            $display("FAIL lock_drop locked=%b exp=0", locked);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_freeze_reset();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (locked !== 1'b1 || ctrl !== 16'd32768) begin
            bad++;
            $display("FAIL freeze_prelock locked=%b ctrl=%0d exp locked=1 ctrl=32768", locked, ctrl);
        end
        freeze = 1; up = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i >= 1) begin
                total++;
                if (ctrl !== 16'd32772 || ctrl !== 16'(m.ctrl) || locked !== m.locked) begin
                    bad++;
                    $display("FAIL freeze_hold i=%0d ctrl=%0d locked=%b exp ctrl=32772 locked=%b", i, ctrl, locked, m.locked);
                end
            end
        end
        up = 0;
        tick(); tick();
        total++;
        if (ctrl !== 16'd32768) begin
            bad++;
            $display("FAIL freeze_acc_kept ctrl=%0d exp=32768", ctrl);
        end
        for (int i = 0; i < 18; i++) tick();
        up = 1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (locked !== 1'b1 || ctrl !== 16'd32772) begin
            bad++;
            $display("FAIL freeze_prereset locked=%b ctrl=%0d exp locked=1 ctrl=32772", locked, ctrl);
        end
        #2;
        rst = 1;
        m = mdl_init(CW, KI, INIT);
        #1;
        total++;
        if (ctrl !== 16'd32768 || locked !== 1'b0 || ctrl_upd !== 1'b0) begin
            bad++;
            $display("FAIL async_reset ctrl=%0d locked=%b upd=%b exp ctrl=32768 locked=0 upd=0", ctrl, locked, ctrl_upd);
        end
        tick();
        rst = 0; up = 0; freeze = 0;
        tick();
    endtask

    task automatic test_saturation();
        s_rst = 0; s_dn = 1;
        for (int i = 0; i < 600; i++) begin
            tick();
            total++;
            if (s_ctrl !== 8'(sm.ctrl) || s_ctrl_upd !== sm.upd || s_ctrl > 8'd128) begin
                bad++;
                $display("FAIL sat_down i=%0d ctrl=%0d upd=%b exp ctrl=%0d upd=%b", i, s_ctrl, s_ctrl_upd, sm.ctrl, sm.upd);
            end
        end
        total++;
        if (s_ctrl !== 8'd0 || sm.acc != 0) begin
            bad++;
            $display("FAIL sat_floor ctrl=%0d exp=0", s_ctrl);
        end
        s_dn = 0; s_up = 1;
        for (int i = 0; i < 1200; i++) begin
            tick();
            total++;
            if (s_ctrl !== 8'(sm.ctrl) || s_locked !== sm.locked) begin
                bad++;
                $display("FAIL sat_up i=%0d ctrl=%0d locked=%b exp ctrl=%0d locked=%b", i, s_ctrl, s_locked, sm.ctrl, sm.locked);
            end
        end
        total++;
        if (s_ctrl !== 8'd255) begin
            bad++;
            $display("FAIL sat_ceiling ctrl=%0d exp=255", s_ctrl);
        end
        s_up = 0;
        tick(); tick();
        total++;
        if (s_ctrl !== 8'd255) begin
            bad++;
            $display("FAIL sat_ceiling_idle ctrl=%0d exp=255", s_ctrl);
        end
    endtask

    task automatic test_random();
        int mode;
        for (int seg = 0; seg < 60; seg++) begin
            mode = int'($urandom_range(0, 3));
            for (int i = 0; i < 50; i++) begin
                case (mode)
                    0: begin up = ($urandom_range(0, 3) == 0); dn = ($urandom_range(0, 3) == 0); end
                    1: begin up = ($urandom_range(0, 1) == 0); dn = 0; end
                    2: begin up = 0; dn = ($urandom_range(0, 1) == 0); end
                    default: begin up = ($urandom_range(0, 15) == 0); dn = up; end
                endcase
                freeze = ($urandom_range(0, 9) == 0);
                tick();
                total++;
                if (ctrl !== 16'(m.ctrl) || ctrl_upd !== m.upd || locked !== m.locked) begin
                    bad++;
                    $display("FAIL random seg=%0d i=%0d ctrl=%0d upd=%b locked=%b exp ctrl=%0d upd=%b locked=%b",
                             seg, i, ctrl, ctrl_upd, locked, m.ctrl, m.upd, m.locked);
                end
            end
        end
        up = 0; dn = 0; freeze = 0;
    endtask

    initial begin
        test_reset();
        test_pump_up();
        test_overlap();
        test_lock();
        test_freeze_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
